sdram_page_arbiter: RTL and testbench

Shares the single full-page SDRAM controller command port (`cmd_pagewrite`/`cmd_pageread`/`cmd_ack`/`cmd_done`/`rowaddr`) among N_CH FIFO channels. It replaces the single-channel transfer negotiator when several pipe endpoints stream to and from SDRAM at once. The arbiter picks one requesting channel per page transaction. It drives the controller handshake and keeps a private row pointer per channel inside a fixed SDRAM region. It exports `sel` so the top level can mux FIFO data and strobes.

---
 rtl/sdram_page_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_page_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_page_arbiter.sv
// Round-robin arbiter sharing one full-page SDRAM command port among N_CH FIFO channels.
// Define SDRAM_ARB_FIXEDPRI_EN for strict lowest-index-wins priority without a round-robin pointer.
module sdram_page_arbiter #(
  parameter int N_CH  = 4,
  parameter int ROW_W = 15,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_write,
  input  logic [N_CH-1:0]   ch_rewind,
  output logic [N_CH-1:0]   ch_grant,
  output logic [N_CH-1:0]   ch_done,
  output logic [N_CH-1:0]   ch_wrap,
  output logic [CH_W-1:0]   sel,
  output logic              busy,
  output logic              cmd_pagewrite,
  output logic              cmd_pageread,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic [ROW_W-1:0]  rowaddr
);

  localparam int RW = ROW_W - CH_W;

  typedef enum logic [1:0] {IDLE, ACKWAIT, BUSY} state_t;

  state_t state, state_next;

  logic [N_CH-1:0][RW-1:0] row;
  logic                    dir_write;
  logic                    any_req;
  logic [CH_W-1:0]         winner;
  logic [N_CH-1:0]         sel_onehot;
  logic                    grant_event;
  logic                    done_event;
  logic                    launch;
  logic                    pagewrite_nxt;
  logic                    pageread_nxt;
  logic [N_CH-1:0]         grant_nxt;
  logic [N_CH-1:0]         done_nxt;
  logic [N_CH-1:0]         wrap_nxt;

`ifdef SDRAM_ARB_FIXEDPRI_EN
  always_comb begin
    any_req = |ch_req;
    winner  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_req[k]) winner = CH_W'(k);
    end
  end
`else
  logic [CH_W-1:0] rr_ptr;
  logic            found;

  // Search upward from the pointer; the index wraps naturally because N_CH is a power of two.
  always_comb begin
    any_req = |ch_req;
    winner  = '0;
    found   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && ch_req[rr_ptr + CH_W'(k)]) begin
        winner = rr_ptr + CH_W'(k);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (done_event) begin
      rr_ptr <= sel + CH_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACKWAIT;
      ACKWAIT: if (cmd_ack) state_next = cmd_done ? IDLE : BUSY;
      BUSY:    if (cmd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs; a done seen in ACKWAIT only counts alongside its ack.
  always_comb begin
    sel_onehot    = N_CH'(1) << sel;
    grant_event   = (state == ACKWAIT) && cmd_ack;
    done_event    = ((state == ACKWAIT) && cmd_ack && cmd_done) ||
                    ((state == BUSY) && cmd_done);
    launch        = (state == IDLE) && any_req;
    pagewrite_nxt = 1'b0;
    pageread_nxt  = 1'b0;
    if (launch) begin
      pagewrite_nxt = ch_write[winner];
      pageread_nxt  = !ch_write[winner];
    end else if ((state == ACKWAIT) && !cmd_ack) begin
      pagewrite_nxt = dir_write;
      pageread_nxt  = !dir_write;
    end
    grant_nxt = grant_event ? sel_onehot : '0;
    done_nxt  = done_event ? sel_onehot : '0;
    wrap_nxt  = (grant_event && !ch_rewind[sel] && (&row[sel])) ? sel_onehot : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_grant      <= '0;
      ch_done       <= '0;
      ch_wrap       <= '0;
      sel           <= '0;
      busy          <= 1'b0;
      cmd_pagewrite <= 1'b0;
      cmd_pageread  <= 1'b0;
      rowaddr       <= '0;
      dir_write     <= 1'b0;
    end else begin
      ch_grant      <= grant_nxt;
      ch_done       <= done_nxt;
      ch_wrap       <= wrap_nxt;
      busy          <= (state_next != IDLE);
      cmd_pagewrite <= pagewrite_nxt;
      cmd_pageread  <= pageread_nxt;
      if (launch) begin
        sel       <= winner;
        dir_write <= ch_write[winner];
        rowaddr   <= {winner, row[winner]};
      end
    end
  end

  // Rewind overrides a coincident increment on the same channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_rewind[i]) begin
          row[i] <= '0;
        end else if (grant_event && (sel == CH_W'(i))) begin
          row[i] <= row[i] + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_page_arbiter.sv
// Directed self-checking bench for sdram_page_arbiter (N_CH=4, ROW_W=15).
// Grant-order expectations follow SDRAM_ARB_FIXEDPRI_EN when it is defined.
module tb_sdram_page_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_req = '0;
  logic [3:0]  ch_write = '0;
  logic [3:0]  ch_rewind = '0;
  logic [3:0]  ch_grant;
  logic [3:0]  ch_done;
  logic [3:0]  ch_wrap;
  logic [1:0]  sel;
  logic        busy;
  logic        cmd_pagewrite;
  logic        cmd_pageread;
  logic        cmd_ack = 1'b0;
  logic        cmd_done = 1'b0;
  logic [14:0] rowaddr;

  int checks = 0;
  int errors = 0;

  sdram_page_arbiter #(.N_CH(4), .ROW_W(15)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_write(ch_write),
    .ch_rewind(ch_rewind), .ch_grant(ch_grant), .ch_done(ch_done),
    .ch_wrap(ch_wrap), .sel(sel), .busy(busy), .cmd_pagewrite(cmd_pagewrite),
    .cmd_pageread(cmd_pageread), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .rowaddr(rowaddr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One quick page: request (left held), ack and done together, returns the granted index.
  task automatic run_txn(input logic [3:0] req, input logic [3:0] wr, output int granted);
    int n;
    ch_req = req;
    ch_write = wr;
    tick();
    n = 0;
    while (!(cmd_pagewrite || cmd_pageread) && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n == 10) begin
      errors++;
      $display("[TB] FAIL txn_timeout: got no command, expected command within 10 cycles");
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
    granted = -1;
    for (int i = 0; i < 4; i++) if (ch_grant[i]) granted = i;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, cmd_pagewrite, cmd_pageread} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {busy, cmd_pagewrite, cmd_pageread});
    end
    checks++;
    if ({ch_grant, ch_done, ch_wrap} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %h expected 000", {ch_grant, ch_done, ch_wrap});
    end
    checks++;
    if ({sel, rowaddr} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h expected 0", {sel, rowaddr});
    end
  endtask

  task automatic test_single_write;
    int high;
    int g;
    logic [3:0] done_seen;
    ch_req = 4'b0010;
    ch_write = 4'b0010;
    tick();
    checks++;
    if (rowaddr !== 15'h2000 || sel !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_issue: got rowaddr=%h sel=%0d busy=%b expected 2000 1 1", rowaddr, sel, busy);
    end
    high = 0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_pagewrite && !cmd_pageread) high++;
      if (i == 2) begin
        cmd_ack = 1'b1;
        ch_req = 4'b0000;
      end
      tick();
    end
    cmd_ack = 1'b0;
    checks++;
    if (high !== 3) begin
      errors++;
      $display("[TB] FAIL single_cmd_len: got %0d expected 3", high);
    end
    checks++;
    if (cmd_pagewrite !== 1'b0 || ch_grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant: got wr=%b grant=%b busy=%b expected 0 0010 1", cmd_pagewrite, ch_grant, busy);
    end
    done_seen = '0;
    for (int i = 0; i < 511; i++) begin
      done_seen = done_seen | ch_done;
      tick();
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checks++;
    if (ch_done !== 4'b0010 || done_seen !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: got done=%b early=%b busy=%b expected 0010 0000 0", ch_done, done_seen, busy);
    end
    ch_req = 4'b0010;
    tick();
    checks++;
    if (rowaddr !== 15'h2001 || cmd_pagewrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_next_row: got %h wr=%b expected 2001 1", rowaddr, cmd_pagewrite);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
    g = 0;
  endtask

  task automatic test_reset_mid_busy;
    int g;
    for (int i = 0; i < 5; i++) run_txn(4'b0100, 4'b0100, g);
    tick();
    cmd_ack = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    checks++;
    if (busy !== 1'b1 || rowaddr !== 15'h4005) begin
      errors++;
      $display("[TB] FAIL mid_busy_setup: got busy=%b rowaddr=%h expected 1 4005", busy, rowaddr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, cmd_pagewrite, cmd_pageread, ch_grant, ch_done, ch_wrap, sel, rowaddr} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy=%b sel=%0d rowaddr=%h expected all 0", busy, sel, rowaddr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ch_req = 4'b0100;
    ch_write = 4'b0000;
    tick();
    checks++;
    if (rowaddr !== 15'h4000 || sel !== 2'd2 || cmd_pageread !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_row: got rowaddr=%h sel=%0d rd=%b expected 4000 2 1", rowaddr, sel, cmd_pageread);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
  endtask

  task automatic test_round_robin;
    int g;
    int exp_order[5];
`ifdef SDRAM_ARB_FIXEDPRI_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 4'b1111, g);
      checks++;
      if (g !== exp_order[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, g, exp_order[i]);
      end
    end
    ch_req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap;
    int g;
    pulse_reset();
    for (int i = 0; i < 8191; i++) run_txn(4'b1000, 4'b1000, g);
    tick();
    checks++;
    if (rowaddr !== 15'h7FFF) begin
      errors++;
      $display("[TB] FAIL wrap_top_row: got %h expected 7fff", rowaddr);
    end
    cmd_ack = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    checks++;
    if (ch_wrap !== 4'b1000 || ch_grant !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL wrap_pulse: got wrap=%b grant=%b expected 1000 1000", ch_wrap, ch_grant);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checks++;
    if (ch_wrap !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL wrap_one_cycle: got %b expected 0000", ch_wrap);
    end
    ch_req = 4'b1000;
    tick();
    checks++;
    if (rowaddr !== 15'h6000) begin
      errors++;
      $display("[TB] FAIL wrap_next_row: got %h expected 6000", rowaddr);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
  endtask

  task automatic test_rewind;
    int g;
    run_txn(4'b0001, 4'b0001, g);
    run_txn(4'b0001, 4'b0001, g);
    tick();
    checks++;
    if (rowaddr !== 15'h0002) begin
      errors++;
      $display("[TB] FAIL rewind_setup: got %h expected 0002", rowaddr);
    end
    cmd_ack = 1'b1;
    ch_rewind = 4'b0001;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    ch_rewind = 4'b0000;
    checks++;
    if (ch_grant !== 4'b0001 || ch_wrap !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rewind_grant: got grant=%b wrap=%b expected 0001 0000", ch_grant, ch_wrap);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    ch_req = 4'b0001;
    tick();
    checks++;
    if (rowaddr !== 15'h0000) begin
      errors++;
      $display("[TB] FAIL rewind_row: got %h expected 0000", rowaddr);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
  endtask

  task automatic test_ack_done_same;
    ch_req = 4'b0010;
    ch_write = 4'b0000;
    tick();
    checks++;
    if (cmd_pageread !== 1'b1 || cmd_pagewrite !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_cmd: got rd=%b wr=%b expected 1 0", cmd_pageread, cmd_pagewrite);
    end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    checks++;
    if (ch_done !== 4'b0000 || cmd_pageread !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_done: got done=%b rd=%b busy=%b expected 0000 1 1", ch_done, cmd_pageread, busy);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
    checks++;
    if (ch_grant !== 4'b0010 || ch_done !== 4'b0010 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_done_pulses: got grant=%b done=%b busy=%b expected 0010 0010 0", ch_grant, ch_done, busy);
    end
    ch_req = 4'b0010;
    tick();
    checks++;
    if (cmd_pageread !== 1'b1 || rowaddr !== 15'h2001) begin
      errors++;
      $display("[TB] FAIL ack_done_idle: got rd=%b rowaddr=%h expected 1 2001", cmd_pageread, rowaddr);
    end
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    ch_req = 4'b0000;
    tick();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    tick();
    reset = 1'b0;
    test_single_write();
    test_reset_mid_busy();
    test_round_robin();
    test_wrap();
    test_rewind();
    test_ack_done_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
